// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Shared state encoding, SRAM request type and parameter defaults
// Revision    : 1.0
// ============================================================================
`default_nettype none

package decode_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UART_RX = 2'd1,
        S_M2      = 2'd2,
        S_M1      = 2'd3
    } seq_state_t;

    localparam logic [25:0] UART_TIMEOUT_DEFAULT = 26'd49999999;
    localparam logic [31:0] WD_LIMIT_DEFAULT     = 32'd20000000;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] wdata;
        logic        we_n;
    } sram_req_t;

endpackage

`default_nettype wire

// File: rtl/sram_port_mux.sv
// ============================================================================
// Module      : sram_port_mux
// Description : Combinational SRAM requester select keyed by sequencer state
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sram_port_mux
    import decode_pkg::*;
(
    input  seq_state_t  state_i,
    input  logic [17:0] vga_addr_i,
    input  sram_req_t   uart_req_i,
    input  sram_req_t   m2_req_i,
    input  sram_req_t   m1_req_i,
    output sram_req_t   sram_req_o
);

    // VGA is read-only, so the idle grant can never write
    always_comb begin
        sram_req_o.addr  = vga_addr_i;
        sram_req_o.wdata = 16'd0;
        sram_req_o.we_n  = 1'b1;
        case (state_i)
            S_UART_RX: sram_req_o = uart_req_i;
            S_M2:      sram_req_o = m2_req_i;
            S_M1:      sram_req_o = m1_req_i;
            default:   ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_sequencer.sv
// ============================================================================
// Module      : decode_sequencer
// Description : UART receive -> milestone 2 -> milestone 1 decode sequencer
//               with SRAM port arbitration. DECODE_WATCHDOG_EN adds a
//               per-phase watchdog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module decode_sequencer
    import decode_pkg::*;
#(
    parameter logic [25:0] UART_TIMEOUT = UART_TIMEOUT_DEFAULT,
    parameter logic [31:0] WD_LIMIT     = WD_LIMIT_DEFAULT
) (
    input  logic        CLOCK_50_I,
    input  logic        reset,
    input  logic        UART_RX_I,
    input  logic [17:0] uart_addr,
    input  logic [15:0] uart_wdata,
    input  logic        uart_we_n,
    input  logic [17:0] vga_addr,
    input  logic [17:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_we_n,
    input  logic [17:0] m2_addr,
    input  logic [15:0] m2_wdata,
    input  logic        m2_we_n,
    input  logic        m1_finish,
    input  logic        m2_finish,
    output logic        uart_init,
    output logic        uart_enable,
    output logic        vga_enable,
    output logic        m1_start,
    output logic        m2_start,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_we_n,
    output logic [1:0]  phase,
    output logic        decode_done,
    output logic        wd_error
);

    seq_state_t  state_q;
    logic [25:0] timer_q;
    logic        uart_init_q;
    logic        uart_enable_q;
    logic        vga_enable_q;
    logic        m1_start_q;
    logic        m2_start_q;
    logic        decode_done_q;
    sram_req_t   sram_req;

`ifdef DECODE_WATCHDOG_EN
    logic [31:0] wd_cnt_q;
    logic        wd_error_q;
    logic        wd_hit;

    assign wd_hit   = (wd_cnt_q == WD_LIMIT);
    assign wd_error = wd_error_q;
`else
    assign wd_error = 1'b0;
`endif

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= 26'd0;
            uart_init_q   <= 1'b0;
            uart_enable_q <= 1'b0;
            vga_enable_q  <= 1'b1;
            m1_start_q    <= 1'b0;
            m2_start_q    <= 1'b0;
            decode_done_q <= 1'b0;
`ifdef DECODE_WATCHDOG_EN
            wd_cnt_q      <= 32'd0;
            wd_error_q    <= 1'b0;
`endif
        end else begin
            uart_init_q   <= 1'b0;
            uart_enable_q <= 1'b0;
            decode_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    vga_enable_q <= 1'b1;
                    m1_start_q   <= 1'b0;
                    m2_start_q   <= 1'b0;
                    if (!UART_RX_I) begin
                        state_q      <= S_UART_RX;
                        uart_init_q  <= 1'b1;
                        timer_q      <= 26'd0;
                        vga_enable_q <= 1'b0;
                    end
                end
                S_UART_RX: begin
                    // Receiver enable follows the init pulse by one cycle
                    uart_enable_q <= uart_init_q;
                    if (!uart_we_n) begin
                        timer_q <= 26'd0;
                    end else if (timer_q == UART_TIMEOUT) begin
                        state_q    <= S_M2;
                        m2_start_q <= 1'b1;
                        timer_q    <= 26'd0;
`ifdef DECODE_WATCHDOG_EN
                        wd_cnt_q   <= 32'd0;
`endif
                    end else begin
                        timer_q <= timer_q + 26'd1;
                    end
                end
                S_M2: begin
                    if (m2_finish) begin
                        state_q    <= S_M1;
                        m2_start_q <= 1'b0;
                        m1_start_q <= 1'b1;
`ifdef DECODE_WATCHDOG_EN
                        wd_cnt_q   <= 32'd0;
                    end else if (wd_hit) begin
                        state_q      <= S_IDLE;
                        m2_start_q   <= 1'b0;
                        vga_enable_q <= 1'b1;
                        wd_error_q   <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
`endif
                    end
                end
                S_M1: begin
                    if (m1_finish) begin
                        state_q       <= S_IDLE;
                        m1_start_q    <= 1'b0;
                        vga_enable_q  <= 1'b1;
                        decode_done_q <= 1'b1;
`ifdef DECODE_WATCHDOG_EN
                    end else if (wd_hit) begin
                        state_q      <= S_IDLE;
                        m1_start_q   <= 1'b0;
                        vga_enable_q <= 1'b1;
                        wd_error_q   <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
`endif
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    vga_enable_q <= 1'b1;
                    m1_start_q   <= 1'b0;
                    m2_start_q   <= 1'b0;
                end
            endcase
        end
    end

    sram_port_mux u_sram_port_mux (
        .state_i    (state_q),
        .vga_addr_i (vga_addr),
        .uart_req_i ({uart_addr, uart_wdata, uart_we_n}),
        .m2_req_i   ({m2_addr, m2_wdata, m2_we_n}),
        .m1_req_i   ({m1_addr, m1_wdata, m1_we_n}),
        .sram_req_o (sram_req)
    );

    assign sram_addr   = sram_req.addr;
    assign sram_wdata  = sram_req.wdata;
    assign sram_we_n   = sram_req.we_n;
    assign phase       = state_q;
    assign uart_init   = uart_init_q;
    assign uart_enable = uart_enable_q;
    assign vga_enable  = vga_enable_q;
    assign m1_start    = m1_start_q;
    assign m2_start    = m2_start_q;
    assign decode_done = decode_done_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_sequencer.sv
// ============================================================================
// Module      : tb_decode_sequencer
// Description : Randomized bench for decode_sequencer against a timestamp model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_decode_sequencer;

    localparam int TO  = 100;
    localparam int WDL = 20;
`ifdef DECODE_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        UART_RX_I;
    logic [17:0] uart_addr, vga_addr, m1_addr, m2_addr;
    logic [15:0] uart_wdata, m1_wdata, m2_wdata;
    logic        uart_we_n, m1_we_n, m2_we_n;
    logic        m1_finish, m2_finish;
    logic        uart_init, uart_enable, vga_enable, m1_start, m2_start;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we_n;
    logic [1:0]  phase;
    logic        decode_done, wd_error;

    always #5 clk = ~clk;

    decode_sequencer #(
        .UART_TIMEOUT (26'd100),
        .WD_LIMIT     (32'd20)
    ) dut (
        .CLOCK_50_I  (clk),
        .reset       (reset),
        .UART_RX_I   (UART_RX_I),
        .uart_addr   (uart_addr),
        .uart_wdata  (uart_wdata),
        .uart_we_n   (uart_we_n),
        .vga_addr    (vga_addr),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_we_n     (m1_we_n),
        .m2_addr     (m2_addr),
        .m2_wdata    (m2_wdata),
        .m2_we_n     (m2_we_n),
        .m1_finish   (m1_finish),
        .m2_finish   (m2_finish),
        .uart_init   (uart_init),
        .uart_enable (uart_enable),
        .vga_enable  (vga_enable),
        .m1_start    (m1_start),
        .m2_start    (m2_start),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_we_n   (sram_we_n),
        .phase       (phase),
        .decode_done (decode_done),
        .wd_error    (wd_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase plus edge timestamps (entry edge, last timer-clearing edge)
    int cyc     = 0;
    int m_phase = 0;
    int m_entry = -100;
    int m_ref   = 0;
    bit m_done  = 1'b0;
    bit m_wd    = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_phase = 0;
            m_wd    = 1'b0;
            m_entry = cyc;
        end else begin
            case (m_phase)
                0: if (!UART_RX_I) begin
                    m_phase = 1; m_entry = cyc; m_ref = cyc;
                end
                1: if (!uart_we_n) m_ref = cyc;
                   else if (cyc == m_ref + TO + 1) begin
                    m_phase = 2; m_entry = cyc;
                end
                2: if (m2_finish) begin
                    m_phase = 3; m_entry = cyc;
                end else if (WD_ON && cyc == m_entry + WDL + 1) begin
                    m_phase = 0; m_wd = 1'b1; m_entry = cyc;
                end
                default: if (m1_finish) begin
                    m_phase = 0; m_done = 1'b1; m_entry = cyc;
                end else if (WD_ON && cyc == m_entry + WDL + 1) begin
                    m_phase = 0; m_wd = 1'b1; m_entry = cyc;
                end
            endcase
        end
    endtask

    task automatic compare();
        logic [6:0]  ectrl;
        logic [34:0] ebus;
        ectrl = {(m_phase == 1 && m_entry == cyc), (m_phase == 1 && m_entry == cyc - 1),
                 (m_phase == 0), (m_phase == 2), (m_phase == 3), m_done, m_wd};
        case (m_phase)
            0:       ebus = {vga_addr, 16'd0, 1'b1};
            1:       ebus = {uart_addr, uart_wdata, uart_we_n};
            2:       ebus = {m2_addr, m2_wdata, m2_we_n};
            default: ebus = {m1_addr, m1_wdata, m1_we_n};
        endcase
        check("phase", 64'(phase), 64'(m_phase));
        check("ctrl", 64'({uart_init, uart_enable, vga_enable, m2_start, m1_start, decode_done, wd_error}),
              64'(ectrl));
        check("sram", 64'({sram_addr, sram_wdata, sram_we_n}), 64'(ebus));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic wait_phase(input int target, input int budget);
        int n;
        n = 0;
        while (m_phase != target && n < budget) begin
            step();
            n++;
        end
        if (m_phase != target) check("wait_timeout", 64'(phase), 64'(target));
    endtask

    task automatic enter_m2();
        UART_RX_I = 1'b0;
        step();
        UART_RX_I = 1'b1;
        uart_we_n = 1'b1;
        wait_phase(2, 400);
    endtask

    int burst = 0;

    initial begin
        reset = 1'b1; UART_RX_I = 1'b1;
        uart_addr = 18'h0AAAA; uart_wdata = 16'h1111; uart_we_n = 1'b0;
        vga_addr = 18'h2BCDE; m1_addr = 18'h00321; m1_wdata = 16'hBEEF; m1_we_n = 1'b0;
        m2_addr = 18'h00456; m2_wdata = 16'hCAFE; m2_we_n = 1'b0;
        m1_finish = 1'b0; m2_finish = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // Start bit, then a write at cycle 50 and a write coincident with the timeout
        UART_RX_I = 1'b0; uart_we_n = 1'b1;
        step();
        UART_RX_I = 1'b1;
        repeat (49) step();
        uart_we_n = 1'b0; step(); uart_we_n = 1'b1;
        for (int i = 0; i < 200 && (cyc + 1 != m_ref + TO + 1); i++) step();
        uart_we_n = 1'b0; step(); uart_we_n = 1'b1;
        check("coincident_stay", 64'(phase), 64'd1);
        wait_phase(2, 300);

        // M2 grant only; foreign finish ignored
        m2_addr = 18'h1234; m2_we_n = 1'b0; m1_we_n = 1'b0; m1_finish = 1'b1;
        repeat (3) step();
        check("m2_addr", 64'(sram_addr), 64'h1234);
        m1_finish = 1'b0; m2_finish = 1'b1;
        step();
        m2_finish = 1'b0;
        step();
        m1_finish = 1'b1;
        step();
        m1_finish = 1'b0;
        check("done_addr", 64'(sram_addr), 64'(vga_addr));
        repeat (2) step();

        // Reset inside M1, then immediate start bit
        enter_m2();
        m2_finish = 1'b1; step(); m2_finish = 1'b0;
        repeat (3) step();
        reset = 1'b1; step();
        reset = 1'b0; UART_RX_I = 1'b0; step();
        UART_RX_I = 1'b1;
        repeat (4) step();
        reset = 1'b1; step(); reset = 1'b0; step();

        // Stall in M2 (watchdog or indefinite wait), then finish coincident with limit
        enter_m2();
        repeat (30) step();
        if (m_phase == 2) begin
            m2_finish = 1'b1; step(); m2_finish = 1'b0;
            m1_finish = 1'b1; step(); m1_finish = 1'b0;
        end
        step();
        enter_m2();
        for (int i = 0; i < 40 && (cyc + 1 != m_entry + WDL + 1); i++) step();
        m2_finish = 1'b1; step(); m2_finish = 1'b0;
        for (int i = 0; i < 40 && (cyc + 1 != m_entry + WDL + 1); i++) step();
        m1_finish = 1'b1; step(); m1_finish = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            uart_addr  = 18'($urandom); uart_wdata = 16'($urandom);
            vga_addr   = 18'($urandom);
            m1_addr    = 18'($urandom); m1_wdata   = 16'($urandom); m1_we_n = 1'($urandom);
            m2_addr    = 18'($urandom); m2_wdata   = 16'($urandom); m2_we_n = 1'($urandom);
            if (m_phase == 1 && m_entry == cyc) burst = $urandom_range(0, 150);
            if (m_phase == 1) begin
                uart_we_n = (burst > 0) ? ($urandom % 8 != 0) : 1'b1;
                if (burst > 0) burst--;
            end else begin
                uart_we_n = 1'($urandom);
            end
            UART_RX_I = ($urandom % 6 != 0);
            m1_finish = ($urandom % 25 == 0);
            m2_finish = ($urandom % 25 == 0);
            reset     = ($urandom % 400 == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter UART_TIMEOUT, default 26'd49999999, meaning the number of idle cycles after the last UART write that ends reception.
REQ-002 SHALL have parameter WD_LIMIT, default 32'd20000000, meaning the maximum cycles allowed per milestone phase (used only under REQ-031).
REQ-003 SHALL have port CLOCK_50_I, input, 1, the single 50 MHz clock; reset SHALL be synchronous and active-high.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port UART_RX_I, input, 1, the raw UART line, used for start-bit detection.
REQ-006 SHALL have ports uart_addr/uart_wdata/uart_we_n, inputs, 18/16/1, the UART requester SRAM port.
REQ-007 SHALL have port vga_addr, input, 18, the VGA requester read address.
REQ-008 SHALL have ports m1_addr/m1_wdata/m1_we_n, m2_addr/m2_wdata/m2_we_n, inputs, 18/16/1 each, the milestone requester ports.
REQ-009 SHALL have ports m1_finish/m2_finish, inputs, 1, the milestone completion levels.
REQ-010 SHALL have ports uart_init/uart_enable, outputs, 1, the UART receiver control.
REQ-011 SHALL have ports vga_enable/m1_start/m2_start, outputs, 1, the requester enables.
REQ-012 SHALL have ports sram_addr/sram_wdata/sram_we_n, outputs, 18/16/1, the arbitrated SRAM controller port.
REQ-013 SHALL have ports phase (output, 2, current state code), decode_done (output, 1, one-cycle pulse) and wd_error (output, 1, sticky watchdog flag).

Function
REQ-014 SHALL implement the states S_IDLE=0, S_UART_RX=1, S_M2=2 and S_M1=3, with phase equal to the state code.
REQ-015 In S_IDLE, SHALL hold vga_enable=1; when UART_RX_I==0, SHALL go to S_UART_RX, pulse uart_init for 1 cycle, clear the timer and drive vga_enable=0.
REQ-016 In S_UART_RX, SHALL assert uart_enable for exactly 1 cycle, beginning the cycle after uart_init.
REQ-017 In S_UART_RX, the 26-bit timer SHALL increment each cycle and SHALL clear on any cycle in which uart_we_n==0.
REQ-018 When the timer equals UART_TIMEOUT and uart_we_n==1, SHALL go to S_M2 with m2_start=1 and the timer cleared.
REQ-019 If uart_we_n==0 in the same cycle the timer equals UART_TIMEOUT, the clear SHALL win and the state SHALL not change.
REQ-020 In S_M2, SHALL hold m2_start high until m2_finish==1 is sampled; in that cycle SHALL set m2_start=0, set m1_start=1 and go to S_M1.
REQ-021 In S_M1, SHALL hold m1_start high until m1_finish==1; in that cycle SHALL set m1_start=0, pulse decode_done and go to S_IDLE with vga_enable=1.
REQ-022 A finish input asserted outside its own phase SHALL be ignored.
REQ-023 The SRAM mux SHALL be combinational on state, with zero added latency.
REQ-024 SRAM mux in S_IDLE SHALL drive {vga_addr, 16'd0, 1}.
REQ-025 SRAM mux in S_UART_RX, S_M2 and S_M1 SHALL pass the UART, M2 and M1 ports respectively.
REQ-026 A requester not granted SHALL never reach sram_we_n; in particular, sram_we_n SHALL be 1 in S_IDLE regardless of inputs.
REQ-027 An illegal state SHALL recover to S_IDLE on the next edge.

Reset
REQ-028 On reset==1 at a clock edge, SHALL set state=S_IDLE, timer=0, uart_init=0, uart_enable=0, m1_start=0, m2_start=0, decode_done=0, wd_error=0 and vga_enable=1.
REQ-029 Reset asserted mid-phase SHALL abort that phase with no finish handshake, and the next start-bit detection SHALL be possible 1 cycle after reset deasserts.
REQ-030 After reset, SHALL be in S_IDLE, so sram_we_n SHALL be 1 and sram_addr SHALL equal vga_addr.

Configuration
REQ-031 With DECODE_WATCHDOG_EN defined, a 32-bit counter SHALL clear on entry to S_M2/S_M1 and count each cycle in them.
REQ-032 With DECODE_WATCHDOG_EN defined and counter==WD_LIMIT, SHALL set wd_error=1 (sticky until reset), drop m1_start/m2_start and go to S_IDLE without pulsing decode_done.
REQ-033 With DECODE_WATCHDOG_EN defined, if the finish input and the watchdog limit occur in the same cycle, finish SHALL win.
REQ-034 Without DECODE_WATCHDOG_EN, no watchdog counter SHALL exist, wd_error SHALL be tied to 0 and phases SHALL wait indefinitely.

Structure
REQ-035 Package decode_pkg SHALL hold the seq_state_t enum (S_IDLE..S_M1), the 26-bit default for UART_TIMEOUT and the 32-bit default for WD_LIMIT.
REQ-036 One sub-module, sram_port_mux (combinational 4-way requester select keyed by seq_state_t), SHALL be instantiated; all sequential logic SHALL remain in decode_sequencer.

Verification
REQ-037 Reset then UART_RX_I=0 for 1 cycle -> uart_init=1 on the next cycle, uart_enable=1 the cycle after, phase=1, vga_enable=0.
REQ-038 UART_TIMEOUT=100 with uart_we_n pulsed low at cycle 50 -> transition to S_M2 exactly 101 cycles after the pulse; a we_n pulse coincident with timer==100 -> no transition.
REQ-039 In S_M2 with m2_addr=18'h1234, m2_we_n=0, m1_we_n=0 -> sram_addr=18'h1234, sram_we_n=0 from M2 only; m1_finish=1 in S_M2 -> no state change.
REQ-040 m2_finish=1 -> next cycle phase=3, m1_start=1, m2_start=0; then m1_finish=1 -> decode_done high for exactly 1 cycle, phase=0, sram_we_n=1, sram_addr=vga_addr.
REQ-041 DECODE_WATCHDOG_EN with WD_LIMIT=20 and m2_finish held 0 -> wd_error=1 and phase=0 after 21 cycles in S_M2, decode_done stays 0.
REQ-042 reset=1 pulsed while in S_M1 -> all outputs at REQ-028 values on the next edge, and m1_start stays 0 thereafter.
